// File: rtl/emulib_ckpt_sequencer.sv
// rtl/emulib_ckpt_sequencer.sv - sequences one checkpoint save/restore through the scan-chain DMA
module emulib_ckpt_sequencer #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 host_clk,
  input  logic                 host_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 cmd_keep_paused,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_status,
  output logic                 emu_pause_req,
  input  logic                 emu_paused,
  output logic                 dma_start,
  output logic                 dma_direction,
  input  logic                 dma_running,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] save_count,
  output logic [CNT_WIDTH-1:0] load_count
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_PAUSE_TMO   = 2'd1;
  localparam logic [1:0] ST_RESUME_TMO  = 2'd2;
  localparam logic [1:0] ST_ILLEGAL     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_START,
    S_WAIT_DONE,
    S_RESUME,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 keep_q, keep_d;
  logic                 dir_q, dir_d;
  logic                 pend_q, pend_d;
  logic [1:0]           status_q, status_d;
  logic                 pause_req_q, pause_req_d;
  logic                 first_wait_q, first_wait_d;
  logic [CNT_WIDTH-1:0] save_q, save_d;
  logic [CNT_WIDTH-1:0] load_q, load_d;

  always_ff @(posedge host_clk) begin
    if (host_rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      keep_q       <= 1'b0;
      dir_q        <= 1'b0;
      pend_q       <= 1'b0;
      status_q     <= ST_OK;
      pause_req_q  <= 1'b0;
      first_wait_q <= 1'b0;
      save_q       <= '0;
      load_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      keep_q       <= keep_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      status_q     <= status_d;
      pause_req_q  <= pause_req_d;
      first_wait_q <= first_wait_d;
      save_q       <= save_d;
      load_q       <= load_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    keep_d       = keep_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    status_d     = status_q;
    pause_req_d  = pause_req_q;
    first_wait_d = 1'b0;
    save_d       = save_q;
    load_d       = load_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          keep_d = cmd_keep_paused;
          dir_d  = (cmd_op == 2'd1);
          pend_d = 1'b0;
          case (cmd_op)
            2'd0, 2'd1: begin
              state_d     = S_PAUSE;
              pause_req_d = 1'b1;
            end
            2'd2: begin
              state_d     = S_RESUME;
              pause_req_d = 1'b0;
            end
            default: begin
              state_d  = S_RESP;
              status_d = ST_ILLEGAL;
            end
          endcase
        end
      end
      S_PAUSE: begin
        if (emu_paused) begin
          state_d = S_START;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = S_RESUME;
          pend_d      = 1'b1;
          pause_req_d = 1'b0;
        end
      end
      S_START: begin
        state_d      = S_WAIT_DONE;
        first_wait_d = 1'b1;
      end
      S_WAIT_DONE: begin
        // The controller may not have raised dma_running yet in the first cycle.
        if (!first_wait_q && !dma_running) begin
          if (dir_q) load_d = load_q + 1'b1;
          else       save_d = save_q + 1'b1;
          if (keep_q) begin
            state_d  = S_RESP;
            status_d = ST_OK;
          end else begin
            state_d     = S_RESUME;
            pause_req_d = 1'b0;
          end
        end
      end
      S_RESUME: begin
        if (!emu_paused) begin
          state_d  = S_RESP;
          status_d = pend_q ? ST_PAUSE_TMO : ST_OK;
        end else if (timer_q == TIMER_LAST) begin
          state_d  = S_RESP;
          status_d = pend_q ? ST_PAUSE_TMO : ST_RESUME_TMO;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)                              timer_d = '0;
    else if (state_q == S_PAUSE || state_q == S_RESUME)  timer_d = timer_q + 1'b1;
    else                                                 timer_d = timer_q;
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_status   = status_q;
  assign dma_start     = (state_q == S_START);
  assign dma_direction = dir_q;
  assign emu_pause_req = pause_req_q;
  assign save_count    = save_q;
  assign load_count    = load_q;

endmodule

// File: tb/tb_emulib_ckpt_sequencer.sv
// tb/tb_emulib_ckpt_sequencer.sv - randomized self-checking bench for emulib_ckpt_sequencer
module tb_emulib_ckpt_sequencer;

  localparam int TO = 16;

  logic        host_clk = 1'b0;
  logic        host_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_keep_paused = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_status;
  logic        emu_pause_req;
  logic        emu_paused = 1'b0;
  logic        dma_start;
  logic        dma_direction;
  logic        dma_running = 1'b0;
  logic        busy;
  logic [15:0] save_count;
  logic [15:0] load_count;

  emulib_ckpt_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .host_clk(host_clk), .host_rst(host_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_keep_paused(cmd_keep_paused),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .emu_pause_req(emu_pause_req), .emu_paused(emu_paused),
    .dma_start(dma_start), .dma_direction(dma_direction), .dma_running(dma_running),
    .busy(busy), .save_count(save_count), .load_count(load_count)
  );

  always #5 host_clk = ~host_clk;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0;
  // environment: clock-gate latency, DMA length, hang[0] blocks pausing, hang[1] blocks resuming
  int emu_lat = 0, dma_len = 0, ecnt = 0, dcnt = 0;
  bit [1:0] hang = 2'b00;
  // per-command observations
  int nstart, start_cyc, preq_hi, preq_fall, run_fall, dir_chg, rlat, T;
  bit start_dir, prev_preq, prev_run, got, stable, rdy_after;
  logic [1:0] rstat;
  logic rpreq;
  // reference model outputs
  int xl, xn;
  logic [1:0] xs;
  logic xp;
  int exp_save = 0, exp_load = 0;

  task automatic step();
    @(posedge host_clk);
    #1;
    cyc++;
    if (host_rst) begin
      dcnt = 0;
      dma_running = 1'b0;
    end else begin
      dma_running = (dcnt > 0);
      if (dcnt > 0) dcnt--;
      if (dma_start) dcnt = dma_len;
    end
    if (emu_pause_req !== emu_paused) begin
      ecnt++;
      if (ecnt > emu_lat && !(emu_pause_req ? hang[0] : hang[1])) begin
        emu_paused = emu_pause_req;
        ecnt = 0;
      end
    end else ecnt = 0;
    if (emu_pause_req) preq_hi++;
    if (prev_preq && !emu_pause_req) preq_fall = cyc;
    if (dma_start) begin nstart++; start_cyc = cyc; start_dir = dma_direction; end
    if (dma_running && dma_direction !== start_dir) dir_chg++;
    if (prev_run && !dma_running) run_fall = cyc;
    prev_preq = emu_pause_req;
    prev_run = dma_running;
  endtask

  // Predicts response latency (cycles after accept), status, dma_start count and pause request
  // at response time from the phase rules: pause wait, DMA run, resume wait, each with timeout.
  function automatic void model(input logic [1:0] op, input bit keep, input bit p0);
    int s, d, r;
    bit paused, pend, resume;
    xn = 0; xs = 2'd0; xp = p0; xl = 0;
    pend = 0; paused = p0; resume = 0; r = 0;
    if (op == 2'd3) begin
      xl = 1; xs = 2'd3;
    end else if (op == 2'd2) begin
      resume = 1; r = 1;
    end else begin
      if (p0) s = 2;
      else if (!hang[0] && emu_lat <= TO - 1) s = 2 + emu_lat;
      else s = 0;
      if (s == 0) begin
        pend = 1; paused = 0; resume = 1; r = 1 + TO;
      end else begin
        xn = 1;
        d = (dma_len + 1 > 2) ? s + dma_len + 1 : s + 2;
        paused = 1;
        if (keep) begin xl = d + 1; xs = 2'd0; xp = 1'b1; end
        else begin resume = 1; r = d + 1; end
      end
    end
    if (resume) begin
      xp = 1'b0;
      if (!paused) begin xl = r + 1; xs = pend ? 2'd1 : 2'd0; end
      else if (!hang[1] && emu_lat <= TO - 1) begin xl = r + emu_lat + 1; xs = 2'd0; end
      else begin xl = r + TO; xs = 2'd2; end
    end
  endfunction

  task automatic run_cmd(input logic [1:0] op, input bit keep, input int hold);
    nstart = 0; start_cyc = -1; preq_hi = 0; preq_fall = -1; run_fall = -1; dir_chg = 0;
    got = 0; rlat = -1; rstat = 2'd0; rpreq = 1'b0; stable = 1; rdy_after = 0;
    T = cyc; cmd_op = op; cmd_keep_paused = keep; cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      cmd_valid = 1'b0;
      if (resp_valid) begin got = 1; rlat = cyc - T; rstat = resp_status; rpreq = emu_pause_req; end
    end
    if (got) begin
      for (int i = 0; i < hold; i++) begin
        step();
        if (resp_valid !== 1'b1 || resp_status !== rstat || cmd_ready !== 1'b0) stable = 0;
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      rdy_after = cmd_ready;
    end
    if (xn == 1) begin
      if (op == 2'd1) exp_load++;
      else exp_save++;
    end
  endtask

  task automatic test_reset();
    host_rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if ({cmd_ready, busy, resp_valid, resp_status, emu_pause_req, dma_start, dma_direction} !== 8'b1000_0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 10000000", {cmd_ready, busy, resp_valid, resp_status, emu_pause_req, dma_start, dma_direction});
    end
    tests_run++;
    if (save_count !== 16'd0 || load_count !== 16'd0) begin
      tests_failed++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", save_count, load_count);
    end
    host_rst = 1'b0;
    step();
    tests_run++;
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_save_resume();
    emu_lat = 3; dma_len = 20; hang = 2'b00;
    model(2'd0, 1'b0, emu_paused);
    run_cmd(2'd0, 1'b0, 0);
    tests_run++;
    if (!got || rlat != xl) begin tests_failed++; $display("FAIL save_latency: got %0d expected %0d", rlat, xl); end
    tests_run++;
    if (nstart != 1 || start_dir !== 1'b0) begin tests_failed++; $display("FAIL save_dma_start: got %0d pulses dir %b expected 1 pulse dir 0", nstart, start_dir); end
    tests_run++;
    if (preq_fall != run_fall + 1) begin tests_failed++; $display("FAIL save_pause_drop: got cycle %0d expected %0d", preq_fall, run_fall + 1); end
    tests_run++;
    if (rstat !== 2'd0) begin tests_failed++; $display("FAIL save_status: got %0d expected 0", rstat); end
    tests_run++;
    if (save_count !== 16'd1 || save_count !== 16'(exp_save)) begin tests_failed++; $display("FAIL save_count: got %0d expected 1", save_count); end
  endtask

  task automatic test_keep_paused_loads();
    emu_lat = 2; dma_len = 5; hang = 2'b00;
    for (int k = 0; k < 2; k++) begin
      model(2'd1, 1'b1, emu_paused);
      run_cmd(2'd1, 1'b1, 0);
      tests_run++;
      if (!got || rlat != xl || rstat !== 2'd0) begin tests_failed++; $display("FAIL keep_load%0d_resp: got lat %0d st %0d expected lat %0d st 0", k, rlat, rstat, xl); end
      tests_run++;
      if (preq_fall != -1 || rpreq !== 1'b1 || emu_pause_req !== 1'b1) begin tests_failed++; $display("FAIL keep_load%0d_pause_req: got fall at %0d req %b expected no fall req 1", k, preq_fall, emu_pause_req); end
      tests_run++;
      if (nstart != 1 || start_dir !== 1'b1 || dir_chg != 0) begin tests_failed++; $display("FAIL keep_load%0d_dma: got %0d pulses dir %b changes %0d expected 1 pulse dir 1", k, nstart, start_dir, dir_chg); end
    end
    tests_run++;
    if (start_cyc - T != 2) begin tests_failed++; $display("FAIL keep_load_fast_start: got %0d expected 2", start_cyc - T); end
    tests_run++;
    if (load_count !== 16'd2 || load_count !== 16'(exp_load)) begin tests_failed++; $display("FAIL load_count: got %0d expected 2", load_count); end
  endtask

  task automatic test_pause_timeout();
    emu_lat = 1; hang = 2'b00;
    model(2'd2, 1'b0, emu_paused);
    run_cmd(2'd2, 1'b0, 0);
    tests_run++;
    if (!got || rlat != xl || rstat !== 2'd0 || emu_paused !== 1'b0) begin tests_failed++; $display("FAIL resume_only: got lat %0d st %0d paused %b expected lat %0d st 0 paused 0", rlat, rstat, emu_paused, xl); end
    emu_lat = 3; hang = 2'b01;
    model(2'd0, 1'b0, emu_paused);
    run_cmd(2'd0, 1'b0, 0);
    hang = 2'b00;
    tests_run++;
    if (nstart != 0) begin tests_failed++; $display("FAIL pause_tmo_no_dma: got %0d pulses expected 0", nstart); end
    tests_run++;
    if (preq_hi != TO) begin tests_failed++; $display("FAIL pause_tmo_req_cycles: got %0d expected %0d", preq_hi, TO); end
    tests_run++;
    if (!got || rstat !== 2'd1 || rlat != xl) begin tests_failed++; $display("FAIL pause_tmo_status: got st %0d lat %0d expected st 1 lat %0d", rstat, rlat, xl); end
  endtask

  task automatic test_illegal_op();
    model(2'd3, 1'b0, emu_paused);
    run_cmd(2'd3, 1'b0, 0);
    tests_run++;
    if (!got || rstat !== 2'd3 || rlat != xl) begin tests_failed++; $display("FAIL illegal_resp: got st %0d lat %0d expected st 3 lat %0d", rstat, rlat, xl); end
    tests_run++;
    if (nstart != 0 || preq_hi != 0) begin tests_failed++; $display("FAIL illegal_side_effects: got %0d starts %0d req cycles expected 0 0", nstart, preq_hi); end
  endtask

  task automatic test_resp_backpressure();
    emu_lat = 1; hang = 2'b00;
    model(2'd2, 1'b0, emu_paused);
    T = cyc; cmd_op = 2'd2; cmd_keep_paused = 1'b0; cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); if (resp_valid) got = 1; end
    tests_run++;
    if (!got || cyc - T != xl) begin tests_failed++; $display("FAIL bp_first_resp: got lat %0d expected %0d", cyc - T, xl); end
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({resp_valid, resp_status, cmd_ready} !== 4'b1000) begin tests_failed++; $display("FAIL bp_hold%0d: got %b expected 1000", i, {resp_valid, resp_status, cmd_ready}); end
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    tests_run++;
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after: got %b expected 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_second_accept: got busy %b expected 1", busy); end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin step(); if (resp_valid) got = 1; end
    tests_run++;
    if (!got || resp_status !== 2'd0) begin tests_failed++; $display("FAIL bp_second_resp: got valid %b st %0d expected 1 0", got, resp_status); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    emu_lat = 1; dma_len = 20; hang = 2'b00;
    cmd_op = 2'd1; cmd_keep_paused = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && !dma_running; i++) step();
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (dma_running !== 1'b1 || dma_direction !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_setup: got running %b dir %b expected 1 1", dma_running, dma_direction); end
    host_rst = 1'b1;
    step();
    tests_run++;
    if ({cmd_ready, busy, resp_valid, resp_status, emu_pause_req, dma_start, dma_direction} !== 8'b1000_0000) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b expected 10000000", {cmd_ready, busy, resp_valid, resp_status, emu_pause_req, dma_start, dma_direction});
    end
    host_rst = 1'b0;
    exp_save = 0; exp_load = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (resp_valid) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL rst_mid_no_resp: got %0d resp cycles expected 0", seen); end
    tests_run++;
    if (save_count !== 16'd0 || load_count !== 16'd0) begin tests_failed++; $display("FAIL rst_mid_counters: got %0d/%0d expected 0/0", save_count, load_count); end
  endtask

  task automatic test_random();
    logic [1:0] op;
    bit keep, ok;
    int hold;
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      keep = 1'($urandom_range(0, 1));
      emu_lat = $urandom_range(0, 5);
      dma_len = $urandom_range(0, 8);
      hold = $urandom_range(0, 3);
      hang = 2'b00;
      if ($urandom_range(0, 5) == 0) hang = 2'b01;
      else if ($urandom_range(0, 5) == 0) hang = 2'b10;
      model(op, keep, emu_paused);
      run_cmd(op, keep, hold);
      tests_run++;
      if (!got || rlat != xl || rstat !== xs) begin tests_failed++; $display("FAIL rnd%0d_resp: op %0d got lat %0d st %0d expected lat %0d st %0d", n, op, rlat, rstat, xl, xs); end
      tests_run++;
      if (nstart != xn || rpreq !== xp || dir_chg != 0) begin tests_failed++; $display("FAIL rnd%0d_side: got starts %0d req %b dirchg %0d expected %0d %b 0", n, nstart, rpreq, dir_chg, xn, xp); end
      if (nstart == 1) begin
        tests_run++;
        if (start_dir !== (op == 2'd1)) begin tests_failed++; $display("FAIL rnd%0d_dir: got %b expected %b", n, start_dir, op == 2'd1); end
      end
      tests_run++;
      if (!stable || rdy_after !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d_handshake: got stable %b ready %b expected 1 1", n, stable, rdy_after); end
      tests_run++;
      if (save_count !== 16'(exp_save) || load_count !== 16'(exp_load)) begin tests_failed++; $display("FAIL rnd%0d_counters: got %0d/%0d expected %0d/%0d", n, save_count, load_count, exp_save, exp_load); end
      hang = 2'b00;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
        if (emu_paused === emu_pause_req && !dma_running) ok = 1;
        else step();
      end
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL rnd%0d_settle: environment did not settle, got req %b paused %b", n, emu_pause_req, emu_paused); end
    end
  endtask

  initial begin
    prev_preq = 0; prev_run = 0; start_dir = 0;
    test_reset();
    test_save_resume();
    test_keep_paused_loads();
    test_pause_timeout();
    test_illegal_op();
    test_resp_backpressure();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
